lbp_mem_sched: RTL and testbench
================================

Name: lbp_mem_sched

Overview:
- Sequences ownership of the single LBP result memory between the CLBP writer and the HCU reader.
- Drives the `sel` input of the existing LBP memory mux.
- Issues start pulses to each unit, waits for their done pulses, and inserts a quiet turnaround gap on every ownership change.
- Repeats CLBP→HCU for NUM_FRAMES frames, with a watchdog timeout and an ownership-violation monitor.

Parameters:
- GAP_CYCLES, 2: turnaround cycles with mem_quiet high on each ownership switch; legal range >= 1.
- NUM_FRAMES, 1: CLBP→HCU passes per start; legal range >= 1.
- TIMEOUT, 65535: max cycles in one run phase before error; counter is 16 bits.
- FW, 4: frame_idx width; NUM_FRAMES <= 2^FW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sequence; sampled in IDLE, DONE or ERR only.
- abort  in  1  synchronous abort, returns to IDLE.
- clbp_done  in  1  one-cycle pulse from CLBP, its frame is written.
- hcu_done  in  1  one-cycle pulse from HCU, its histogram read is complete.
- clbp_wen_mon  in  1  copy of CLBP write enable (1 = write request), for monitoring.
- sel  out  1  mux select; 0 = CLBP owns memory, 1 = HCU owns it.
- mem_quiet  out  1  high during gaps; both units must not access memory.
- clbp_start  out  1  one-cycle start pulse to CLBP.
- hcu_start  out  1  one-cycle start pulse to HCU.
- busy  out  1  high from the cycle after start is accepted until DONE, ERR or IDLE.
- frame_idx  out  FW  current frame number, 0-based.
- finish  out  1  one-cycle pulse when all frames complete.
- err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 timeout, 10 ownership violation.

Behaviour:
- Reset values: all outputs 0, state IDLE, watchdog 0. Reset mid-operation returns immediately to these values; the in-flight frame is abandoned.
- All outputs are registered.
- States: IDLE, C_RUN, GAP_C2H, H_RUN, GAP_H2C, DONE, ERR.
- IDLE/DONE/ERR + start:
  - Next state C_RUN; sel=0; clbp_start=1 for the first C_RUN cycle only.
  - frame_idx=0, err=0, err_code=00, busy=1.
  - Latency: start sampled at edge k → clbp_start high in cycle k..k+1.
- C_RUN:
  - clbp_done → GAP_C2H, mem_quiet=1, gap counter = GAP_CYCLES-1.
  - hcu_done is ignored.
- GAP_C2H:
  - Counter decrements each cycle.
  - At 0 → H_RUN; sel=1, mem_quiet=0 and hcu_start=1 are all asserted in the first H_RUN cycle.
  - mem_quiet is high for exactly GAP_CYCLES cycles.
- H_RUN, on hcu_done:
  - If frame_idx==NUM_FRAMES-1 → DONE: sel=0, finish=1 for one cycle, busy=0.
  - Otherwise → GAP_H2C: sel=0, mem_quiet=1.
  - clbp_done is ignored.
- GAP_H2C: same countdown as GAP_C2H; at 0 → C_RUN, frame_idx+1, clbp_start pulse.
- DONE: held one cycle (finish high) → IDLE unless start is also high that cycle.
- Watchdog:
  - Cleared on entry to C_RUN/H_RUN; increments each cycle in those states.
  - Reaching TIMEOUT → ERR, err_code=01.
  - A done pulse in the same cycle as the timeout wins: done transition taken, no error.
- Ownership violation:
  - Trigger: clbp_wen_mon=1 while in H_RUN, GAP_C2H or GAP_H2C → ERR, err_code=10.
  - Takes priority over done and timeout in the same cycle.
- ERR:
  - sel=0, mem_quiet=0, busy=0, no start pulses; err=1 until the next accepted start.
  - frame_idx frozen.
- abort:
  - In any busy state → IDLE next cycle; sel=0, mem_quiet=0, busy=0, no finish; err/err_code unchanged.
  - Takes priority over every other event. Ignored in IDLE.
- start while busy is ignored.
- frame_idx is never incremented past NUM_FRAMES-1.

Decomposition:
- Package lbp_sched_pkg holds:
  - state encoding constants (IDLE..ERR);
  - err_code constants ERR_NONE, ERR_TIMEOUT, ERR_OWN;
  - watchdog width constant WDT_W=16.
- One natural sub-module: lbp_sched_wdt.
  - 16-bit counter with clear, enable and TIMEOUT compare; outputs expire.
- FSM, gap counter and frame counter stay in lbp_mem_sched.

Test Plan (GAP_CYCLES=2, NUM_FRAMES=2, TIMEOUT=100 unless noted):
- Normal two frames:
  - Stimulus: start pulse; clbp_done 10 cycles after each clbp_start; hcu_done 8 cycles after each hcu_start.
  - Required: sel sequence 0→1→0→1→0; mem_quiet high exactly 2 cycles per switch.
  - Required: frame_idx 0 then 1; one finish pulse; busy low after finish.
- Latency/pulse widths: clbp_start one cycle after start is sampled; hcu_start coincides with the first sel=1 cycle; every pulse is exactly 1 cycle wide.
- Timeout:
  - Stimulus: withhold hcu_done.
  - Required: ERR after 100 H_RUN cycles; err=1, err_code=01, sel=0, busy=0.
  - Required: a new start clears err and restarts at frame_idx=0.
- Ownership violation:
  - Stimulus: clbp_wen_mon=1 during the second gap cycle, with clbp_done asserted in the same cycle.
  - Required: ERR, err_code=10, no hcu_start.
- Abort and reset mid-run:
  - Stimulus: abort in H_RUN of frame 1.
  - Required: IDLE next cycle, no finish, sel=0.
  - Stimulus: rst_n low mid-GAP.
  - Required: all outputs 0 asynchronously.
- Edge cases:
  - NUM_FRAMES=1, GAP_CYCLES=1: a single 1-cycle gap, then finish.
  - start while busy: ignored.
  - Stray hcu_done in C_RUN: ignored.
  - clbp_done and timeout in the same cycle: done wins.

Source files
------------

// File: rtl/lbp_sched_pkg.sv
// Shared definitions for the LBP memory ownership scheduler.
//   state_t    : scheduler FSM state encoding
//   ERR_*      : err_code values reported on the err_code output
//   WDT_W      : watchdog counter width
package lbp_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_C_RUN   = 3'd1,
      S_GAP_C2H = 3'd2,
      S_H_RUN   = 3'd3,
      S_GAP_H2C = 3'd4,
      S_DONE    = 3'd5,
      S_ERR     = 3'd6
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_OWN     = 2'b10;

   localparam int WDT_W = 16;

endpackage

// File: rtl/lbp_sched_wdt.sv
// Run-phase watchdog for the LBP memory scheduler.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : hold the count at zero
//   i_en       : count one cycle of a run phase
//   o_expire   : high in the TIMEOUT-th enabled cycle since the last clear
module lbp_sched_wdt
   import lbp_sched_pkg::*;
#(
   parameter int TIMEOUT = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   logic [WDT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // The count is 0 in the first run cycle, so TIMEOUT-1 marks the last one.
   assign o_expire = i_en && (r_cnt == WDT_W'(TIMEOUT - 1));

endmodule

// File: rtl/lbp_mem_sched.sv
// LBP result memory ownership scheduler.
// Hands the single LBP memory between the CLBP writer (sel=0) and the HCU
// reader (sel=1), with a quiet gap on every ownership change, repeated for
// NUM_FRAMES frames. A watchdog bounds each run phase and any CLBP write
// request seen while CLBP does not own the memory is flagged.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, abort        : sequence control
//   clbp_done, hcu_done : one-cycle completion pulses from the units
//   clbp_wen_mon        : CLBP write enable copy for ownership monitoring
//   sel, mem_quiet      : memory mux select and quiet-gap indicator
//   clbp_start,hcu_start: one-cycle start pulses to the units
//   busy, frame_idx     : sequence in progress, current frame
//   finish, err,err_code: completion pulse, sticky error and its cause
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for start
// C_RUN     | CLBP owns memory, waiting for clbp_done
// GAP_C2H   | quiet gap before handing memory to HCU
// H_RUN     | HCU owns memory, waiting for hcu_done
// GAP_H2C   | quiet gap before handing memory back to CLBP
// DONE      | all frames complete, finish pulse
// ERR       | timeout or ownership violation, waiting for start
module lbp_mem_sched
   import lbp_sched_pkg::*;
#(
   parameter int GAP_CYCLES = 2,
   parameter int NUM_FRAMES = 1,
   parameter int TIMEOUT    = 65535,
   parameter int FW         = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          clbp_done,
   input  logic          hcu_done,
   input  logic          clbp_wen_mon,
   output logic          sel,
   output logic          mem_quiet,
   output logic          clbp_start,
   output logic          hcu_start,
   output logic          busy,
   output logic [FW-1:0] frame_idx,
   output logic          finish,
   output logic          err,
   output logic [1:0]    err_code
);

   localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GC_W-1:0] GAP_LOAD   = GC_W'(GAP_CYCLES - 1);
   localparam logic [FW-1:0]   LAST_FRAME = FW'(NUM_FRAMES - 1);

   state_t          r_state;
   logic [GC_W-1:0] r_gap_cnt;

   logic w_run;
   logic w_expire;
   logic w_own_viol;

   assign w_run = (r_state == S_C_RUN) || (r_state == S_H_RUN);

   // CLBP may only write while it owns the memory and the bus is not quiet.
   assign w_own_viol = clbp_wen_mon &&
                       ((r_state == S_H_RUN) || (r_state == S_GAP_C2H) ||
                        (r_state == S_GAP_H2C));

   // Holding the count clear outside run phases makes every run-phase entry
   // start from zero without an explicit entry strobe.
   lbp_sched_wdt #(
      .TIMEOUT (TIMEOUT)
   ) u_wdt (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clr    (!w_run),
      .i_en     (w_run),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_gap_cnt  <= '0;
         sel        <= 1'b0;
         mem_quiet  <= 1'b0;
         clbp_start <= 1'b0;
         hcu_start  <= 1'b0;
         busy       <= 1'b0;
         frame_idx  <= '0;
         finish     <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         clbp_start <= 1'b0;
         hcu_start  <= 1'b0;
         finish     <= 1'b0;

         if (abort && (r_state != S_IDLE)) begin
            r_state   <= S_IDLE;
            sel       <= 1'b0;
            mem_quiet <= 1'b0;
            busy      <= 1'b0;
         end else if (w_own_viol) begin
            r_state   <= S_ERR;
            sel       <= 1'b0;
            mem_quiet <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b1;
            err_code  <= ERR_OWN;
         end else begin
            case (r_state)
               S_IDLE, S_DONE, S_ERR: begin
                  if (start) begin
                     r_state    <= S_C_RUN;
                     sel        <= 1'b0;
                     mem_quiet  <= 1'b0;
                     clbp_start <= 1'b1;
                     busy       <= 1'b1;
                     frame_idx  <= '0;
                     err        <= 1'b0;
                     err_code   <= ERR_NONE;
                  end else if (r_state == S_DONE) begin
                     r_state <= S_IDLE;
                  end
               end

               S_C_RUN: begin
                  // A done pulse in the expiry cycle still counts as success.
                  if (clbp_done) begin
                     r_state   <= S_GAP_C2H;
                     mem_quiet <= 1'b1;
                     r_gap_cnt <= GAP_LOAD;
                  end else if (w_expire) begin
                     r_state  <= S_ERR;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                     err_code <= ERR_TIMEOUT;
                  end
               end

               S_GAP_C2H: begin
                  if (r_gap_cnt == '0) begin
                     r_state   <= S_H_RUN;
                     sel       <= 1'b1;
                     mem_quiet <= 1'b0;
                     hcu_start <= 1'b1;
                  end else begin
                     r_gap_cnt <= r_gap_cnt - 1'b1;
                  end
               end

               S_H_RUN: begin
                  if (hcu_done) begin
                     sel <= 1'b0;
                     if (frame_idx == LAST_FRAME) begin
                        r_state <= S_DONE;
                        finish  <= 1'b1;
                        busy    <= 1'b0;
                     end else begin
                        r_state   <= S_GAP_H2C;
                        mem_quiet <= 1'b1;
                        r_gap_cnt <= GAP_LOAD;
                     end
                  end else if (w_expire) begin
                     r_state  <= S_ERR;
                     sel      <= 1'b0;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                     err_code <= ERR_TIMEOUT;
                  end
               end

               S_GAP_H2C: begin
                  if (r_gap_cnt == '0) begin
                     r_state    <= S_C_RUN;
                     mem_quiet  <= 1'b0;
                     clbp_start <= 1'b1;
                     if (frame_idx != LAST_FRAME) begin
                        frame_idx <= frame_idx + 1'b1;
                     end
                  end else begin
                     r_gap_cnt <= r_gap_cnt - 1'b1;
                  end
               end

               default: begin
                  r_state   <= S_IDLE;
                  sel       <= 1'b0;
                  mem_quiet <= 1'b0;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lbp_mem_sched.sv
// Directed testbench for lbp_mem_sched.
// Instance a: GAP_CYCLES=2, NUM_FRAMES=2, TIMEOUT=100.
// Instance b: GAP_CYCLES=1, NUM_FRAMES=1, TIMEOUT=100.
// Output vector layout: {sel, mem_quiet, clbp_start, hcu_start, busy,
//                        finish, err, err_code[1:0], frame_idx[3:0]}
module tb_lbp_mem_sched;

   logic clk = 1'b0;
   logic rst_n;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic clbp_done = 1'b0;
   logic hcu_done = 1'b0;
   logic clbp_wen_mon = 1'b0;

   logic       a_sel, a_mq, a_cs, a_hs, a_busy, a_fin, a_err;
   logic [3:0] a_fidx;
   logic [1:0] a_code;
   logic       b_sel, b_mq, b_cs, b_hs, b_busy, b_fin, b_err;
   logic [3:0] b_fidx;
   logic [1:0] b_code;

   logic [12:0] obs_a, obs_b;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lbp_mem_sched #(.GAP_CYCLES(2), .NUM_FRAMES(2), .TIMEOUT(100), .FW(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .clbp_done(clbp_done), .hcu_done(hcu_done), .clbp_wen_mon(clbp_wen_mon),
      .sel(a_sel), .mem_quiet(a_mq), .clbp_start(a_cs), .hcu_start(a_hs),
      .busy(a_busy), .frame_idx(a_fidx), .finish(a_fin), .err(a_err),
      .err_code(a_code));

   lbp_mem_sched #(.GAP_CYCLES(1), .NUM_FRAMES(1), .TIMEOUT(100), .FW(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .clbp_done(clbp_done), .hcu_done(hcu_done), .clbp_wen_mon(clbp_wen_mon),
      .sel(b_sel), .mem_quiet(b_mq), .clbp_start(b_cs), .hcu_start(b_hs),
      .busy(b_busy), .frame_idx(b_fidx), .finish(b_fin), .err(b_err),
      .err_code(b_code));

   assign obs_a = {a_sel, a_mq, a_cs, a_hs, a_busy, a_fin, a_err, a_code, a_fidx};
   assign obs_b = {b_sel, b_mq, b_cs, b_hs, b_busy, b_fin, b_err, b_code, b_fidx};

   function automatic logic [12:0] ev(input logic s, input logic q, input logic cs,
                                      input logic hs, input logic b, input logic f,
                                      input logic e, input logic [1:0] code,
                                      input logic [3:0] fi);
      return {s, q, cs, hs, b, f, e, code, fi};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 1'b0; abort = 1'b0; clbp_done = 1'b0;
      hcu_done = 1'b0; clbp_wen_mon = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      n_vec++;
      if (obs_a !== 13'b0) begin
         n_err++; $display("FAIL reset_a got %b exp %b", obs_a, 13'b0);
      end
      n_vec++;
      if (obs_b !== 13'b0) begin
         n_err++; $display("FAIL reset_b got %b exp %b", obs_b, 13'b0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
   endtask

   // Two frames; includes a stray hcu_done in C_RUN, a stray clbp_done in
   // H_RUN and a start while busy, all of which must be ignored.
   task automatic test_normal();
      logic [12:0] exp_v;
      logic s, q, cs, hs, b, f;
      logic [3:0] fi;
      for (int c = 0; c < 48; c++) begin
         start     = (c == 0) || (c == 30);
         clbp_done = (c == 11) || (c == 35) || (c == 18);
         hcu_done  = (c == 5) || (c == 22) || (c == 46);
         tick();
         s  = ((c + 1) >= 14 && (c + 1) <= 22) || ((c + 1) >= 38 && (c + 1) <= 46);
         q  = ((c + 1) == 12) || ((c + 1) == 13) || ((c + 1) == 23) ||
              ((c + 1) == 24) || ((c + 1) == 36) || ((c + 1) == 37);
         cs = ((c + 1) == 1) || ((c + 1) == 25);
         hs = ((c + 1) == 14) || ((c + 1) == 38);
         b  = ((c + 1) >= 1) && ((c + 1) <= 46);
         f  = ((c + 1) == 47);
         fi = ((c + 1) >= 25) ? 4'd1 : 4'd0;
         exp_v = ev(s, q, cs, hs, b, f, 1'b0, 2'b00, fi);
         n_vec++;
         if (obs_a !== exp_v) begin
            n_err++;
            $display("FAIL normal cycle=%0d got %b exp %b", c + 1, obs_a, exp_v);
         end
      end
      clear_inputs();
   endtask

   // hcu_done withheld: ERR after exactly 100 H_RUN cycles.
   task automatic test_timeout();
      for (int c = 0; c < 106; c++) begin
         start     = (c == 0);
         clbp_done = (c == 3);
         tick();
         if (c + 1 == 6) begin
            n_vec++;
            if (obs_a !== ev(1, 0, 0, 1, 1, 0, 0, 2'b00, 4'd0)) begin
               n_err++; $display("FAIL timeout_hstart got %b exp %b", obs_a,
                                 ev(1, 0, 0, 1, 1, 0, 0, 2'b00, 4'd0));
            end
         end
         if (c + 1 == 105) begin
            n_vec++;
            if (obs_a !== ev(1, 0, 0, 0, 1, 0, 0, 2'b00, 4'd0)) begin
               n_err++; $display("FAIL timeout_last_run got %b exp %b", obs_a,
                                 ev(1, 0, 0, 0, 1, 0, 0, 2'b00, 4'd0));
            end
         end
         if (c + 1 == 106) begin
            n_vec++;
            if (obs_a !== ev(0, 0, 0, 0, 0, 0, 1, 2'b01, 4'd0)) begin
               n_err++; $display("FAIL timeout_err got %b exp %b", obs_a,
                                 ev(0, 0, 0, 0, 0, 0, 1, 2'b01, 4'd0));
            end
         end
      end
      clear_inputs();
   endtask

   // Restart from ERR clears err; clbp_done in the expiry cycle wins.
   task automatic test_done_vs_timeout();
      for (int c = 0; c <= 100; c++) begin
         start     = (c == 0);
         clbp_done = (c == 100);
         tick();
         if (c + 1 == 1) begin
            n_vec++;
            if (obs_a !== ev(0, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0)) begin
               n_err++; $display("FAIL restart_clears_err got %b exp %b", obs_a,
                                 ev(0, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
            end
         end
         if (c + 1 == 100) begin
            n_vec++;
            if (obs_a !== ev(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'd0)) begin
               n_err++; $display("FAIL crun_cycle100 got %b exp %b", obs_a,
                                 ev(0, 0, 0, 0, 1, 0, 0, 2'b00, 4'd0));
            end
         end
         if (c + 1 == 101) begin
            n_vec++;
            if (obs_a !== ev(0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0)) begin
               n_err++; $display("FAIL done_beats_timeout got %b exp %b", obs_a,
                                 ev(0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0));
            end
         end
      end
      clear_inputs();
   endtask

   // Continues in the gap left by test_done_vs_timeout.
   task automatic test_own_violation();
      tick();
      n_vec++;
      if (obs_a !== ev(0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0)) begin
         n_err++; $display("FAIL own_gap2 got %b exp %b", obs_a,
                           ev(0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0));
      end
      clbp_wen_mon = 1'b1;
      clbp_done    = 1'b1;
      tick();
      n_vec++;
      if (obs_a !== ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0)) begin
         n_err++; $display("FAIL own_err got %b exp %b", obs_a,
                           ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0));
      end
      clear_inputs();
      tick();
      n_vec++;
      if (obs_a !== ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0)) begin
         n_err++; $display("FAIL own_err_hold got %b exp %b", obs_a,
                           ev(0, 0, 0, 0, 0, 0, 1, 2'b10, 4'd0));
      end
   endtask

   task automatic test_abort();
      for (int c = 0; c <= 40; c++) begin
         start     = (c == 0);
         clbp_done = (c == 11) || (c == 35);
         hcu_done  = (c == 22);
         abort     = (c == 40);
         tick();
         if (c + 1 == 1) begin
            n_vec++;
            if (obs_a !== ev(0, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0)) begin
               n_err++; $display("FAIL abort_restart got %b exp %b", obs_a,
                                 ev(0, 0, 1, 0, 1, 0, 0, 2'b00, 4'd0));
            end
         end
         if (c + 1 == 38) begin
            n_vec++;
            if (obs_a !== ev(1, 0, 0, 1, 1, 0, 0, 2'b00, 4'd1)) begin
               n_err++; $display("FAIL abort_hrun1 got %b exp %b", obs_a,
                                 ev(1, 0, 0, 1, 1, 0, 0, 2'b00, 4'd1));
            end
         end
         if (c + 1 == 41) begin
            n_vec++;
            if (obs_a !== ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd1)) begin
               n_err++; $display("FAIL abort_idle got %b exp %b", obs_a,
                                 ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd1));
            end
         end
      end
      clear_inputs();
      tick();
      n_vec++;
      if (obs_a !== ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd1)) begin
         n_err++; $display("FAIL abort_no_finish got %b exp %b", obs_a,
                           ev(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'd1));
      end
   endtask

   task automatic test_reset_midgap();
      for (int c = 0; c < 4; c++) begin
         start     = (c == 0);
         clbp_done = (c == 3);
         tick();
      end
      clear_inputs();
      n_vec++;
      if (obs_a !== ev(0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0)) begin
         n_err++; $display("FAIL midgap_before_rst got %b exp %b", obs_a,
                           ev(0, 1, 0, 0, 1, 0, 0, 2'b00, 4'd0));
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs_a !== 13'b0) begin
         n_err++; $display("FAIL midgap_async_rst got %b exp %b", obs_a, 13'b0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
   endtask

   // Instance b: one frame, one-cycle gap, then restart straight from DONE.
   task automatic test_single_frame();
      logic [12:0] exp_v;
      logic s, q, cs, hs, b, f;
      for (int c = 0; c < 9; c++) begin
         start     = (c == 0) || (c == 8);
         clbp_done = (c == 3);
         hcu_done  = (c == 7);
         tick();
         s  = ((c + 1) >= 5) && ((c + 1) <= 7);
         q  = ((c + 1) == 4);
         cs = ((c + 1) == 1) || ((c + 1) == 9);
         hs = ((c + 1) == 5);
         b  = (((c + 1) >= 1) && ((c + 1) <= 7)) || ((c + 1) == 9);
         f  = ((c + 1) == 8);
         exp_v = ev(s, q, cs, hs, b, f, 1'b0, 2'b00, 4'd0);
         n_vec++;
         if (obs_b !== exp_v) begin
            n_err++;
            $display("FAIL single_frame cycle=%0d got %b exp %b", c + 1, obs_b, exp_v);
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_timeout();
      test_done_vs_timeout();
      test_own_violation();
      test_abort();
      test_reset_midgap();
      test_single_frame();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
